// File: rtl/bci_fir_pkg.sv
// Shared constants for the EEG lowpass FIR scheduler: fixed-point widths, the
// 16-tap coefficient table and the scheduler state encoding.
package bci_fir_pkg;

  localparam int DATA_W   = 32;  // Q2.29 samples
  localparam int COEF_W   = 16;  // Q0.15 coefficients
  localparam int ACC_W    = 52;
  localparam int NUM_TAPS = 16;

  // Symmetric lowpass; index 0 pairs with the newest sample.
  localparam logic signed [COEF_W-1:0] COEFF [0:NUM_TAPS-1] = '{
    -16'sd48,   -16'sd47,   16'sd354,   -16'sd923,
    16'sd1301,  -16'sd472,  -16'sd3268, 16'sd19486,
    16'sd19486, -16'sd3268, -16'sd472,  16'sd1301,
    -16'sd923,  16'sd354,   -16'sd47,   -16'sd48
  };

  typedef enum logic [2:0] {
    ST_ARB,
    ST_WRITE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } fir_sched_state_t;

endpackage

// File: rtl/fir_hist_ram.sv
// Per-channel sample history: simple dual-port RAM, one write port and one
// synchronous read port, addressed as {channel, tap index}.
module fir_hist_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Shares one 16-tap MAC across NUM_CH channels: round-robin grant, history
// write, TAPS-cycle MAC with a 3-stage pipeline, then a held output beat.
module fir_tdm_scheduler
  import bci_fir_pkg::*;
#(
  parameter int  NUM_CH = 8,
  parameter int  TAPS   = NUM_TAPS,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int IDX_W  = $clog2(TAPS),
  localparam int FILL_W = $clog2(TAPS + 1),
  localparam int PROD_W = DATA_W + COEF_W,
  localparam int FRAC_SH = 14,
  localparam int STAGES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH-1:0][DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]             ch_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic [DATA_W-1:0]             out_data
);

  fir_sched_state_t          state;
  logic [CH_W-1:0]           rr_ptr, cur_ch, hit_ch;
  logic [CH_W:0]             cand;
  logic                      hit, grant, primed;
  logic [DATA_W-1:0]         cur_data, rd_data;
  logic [IDX_W-1:0]          wptr [NUM_CH];
  logic [FILL_W-1:0]         fill [NUM_CH];
  logic [IDX_W-1:0]          nidx, tap_cnt, tap_d, rd_idx;
  logic [1:0]                drain_cnt;
  logic [STAGES:0]           vld_pipe;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic [ACC_W-2-(FRAC_SH+DATA_W-1):0] acc_unused;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    cand   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!hit && ch_valid[cand[CH_W-1:0]]) begin
        hit    = 1'b1;
        hit_ch = cand[CH_W-1:0];
      end
    end
  end

  assign grant      = (state == ST_ARB) && en && !rst && hit;
  assign ch_ready   = grant ? (NUM_CH'(1) << hit_ch) : '0;
  assign rd_idx     = nidx - tap_cnt;  // TAPS is a power of two, so this wraps mod TAPS
  assign acc_unused = acc[ACC_W-2:FRAC_SH+DATA_W-1];

  fir_hist_ram #(.DEPTH(NUM_CH*TAPS), .AW(CH_W+IDX_W), .DW(DATA_W)) u_hist (
    .clk  (clk),
    .we   ((state == ST_WRITE) && en && !rst),
    .waddr({cur_ch, wptr[cur_ch]}),
    .wdata(cur_data),
    .raddr({cur_ch, rd_idx}),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      cur_data  <= '0;
      nidx      <= '0;
      tap_cnt   <= '0;
      tap_d     <= '0;
      drain_cnt <= '0;
      primed    <= 1'b0;
      vld_pipe  <= '0;
      prod      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        fill[i] <= '0;
      end
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == ST_MAC};
      tap_d    <= tap_cnt;
      if (vld_pipe[0]) prod <= $signed(rd_data) * COEFF[tap_d];
      if (vld_pipe[1]) acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      case (state)
        ST_ARB: if (grant) begin
          cur_ch   <= hit_ch;
          cur_data <= ch_data[hit_ch];
          rr_ptr   <= (hit_ch == CH_W'(NUM_CH-1)) ? '0 : hit_ch + 1'b1;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          nidx         <= wptr[cur_ch];
          wptr[cur_ch] <= (wptr[cur_ch] == IDX_W'(TAPS-1)) ? '0 : wptr[cur_ch] + 1'b1;
          if (fill[cur_ch] != FILL_W'(TAPS)) fill[cur_ch] <= fill[cur_ch] + 1'b1;
          primed  <= (fill[cur_ch] >= FILL_W'(TAPS-1));
          acc     <= '0;
          tap_cnt <= '0;
          state   <= ST_MAC;
        end
        ST_MAC: begin
          tap_cnt <= tap_cnt + 1'b1;
          if (tap_cnt == IDX_W'(TAPS-1)) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) begin
            // Unprimed results still occupy the output slot (idle) so grant spacing stays fixed.
            out_valid <= primed;
            if (primed) begin
              out_ch   <= cur_ch;
              out_data <= {acc[ACC_W-1], acc[FRAC_SH+DATA_W-2:FRAC_SH]};
            end
            state <= ST_OUT;
          end
        end
        ST_OUT: if (!out_valid || out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler: impulse, round-robin, backpressure,
// DC gain, flush and reset-in-OUT with hand-computed expectations.
module tb_fir_tdm_scheduler;

  localparam int NCH = 8;

  logic                 clk = 1'b0;
  logic                 rst, en, out_ready, out_valid;
  logic [NCH-1:0]       ch_valid, ch_ready;
  logic [NCH-1:0][31:0] ch_data;
  logic [2:0]           out_ch;
  logic [31:0]          out_data;

  typedef struct {
    int          ch;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  ev_t oq[$];
  ev_t gq[$];
  ev_t mon_o, mon_g;
  int  n_chk = 0, n_err = 0, cyc = 0;
  int  g, g_imp, bad, early;
  int  coef [16] = '{-48, -47, 354, -923, 1301, -472, -3268, 19486,
                     19486, -3268, -472, 1301, -923, 354, -47, -48};

  fir_tdm_scheduler #(.NUM_CH(NCH), .TAPS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_o.ch = int'(out_ch); mon_o.d = out_data; mon_o.cyc = cyc;
      oq.push_back(mon_o);
    end
    for (int i = 0; i < NCH; i++) if (ch_ready[i]) begin
      mon_g.ch = i; mon_g.d = '0; mon_g.cyc = cyc;
      gq.push_back(mon_g);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_valid = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input logic [31:0] d, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    ch_data[ch] = d; ch_valid[ch] = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (ch_ready[ch]) begin got = 1'b1; gcyc = cyc; end
    end
    chk($sformatf("grant_ch%0d", ch), 32'(got), 32'd1);
    @(posedge clk); #1;
    ch_valid[ch] = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; out_ready = 1'b1; ch_valid = '0; ch_data = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ch_ready",  32'(ch_ready),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_out_data",  out_data,       32'd0);

    // Impulse response on ch0
    tick(1);
    oq.delete();
    for (int i = 0; i < 31; i++) begin
      send(0, (i == 15) ? 32'h2000_0000 : 32'h0, g);
      if (i == 15) g_imp = g;
    end
    tick(30);
    chk("imp_count", 32'(oq.size()), 32'd16);
    if (oq.size() >= 16) begin
      chk("imp_first",   oq[0].d, 32'hFFE8_0000);
      chk("imp_eighth",  oq[7].d, 32'h260F_0000);
      chk("imp_latency", 32'(oq[0].cyc - g_imp), 32'd21);
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("imp_ch_%0d", i),  32'(oq[i].ch), 32'd0);
        chk($sformatf("imp_tap_%0d", i), oq[i].d, 32'(coef[i] * 32768));
      end
    end

    // Round-robin with every channel requesting
    do_reset();
    oq.delete(); gq.delete();
    ch_data = '0; ch_valid = '1;
    for (int t = 0; t < 3200 && gq.size() < 129; t++) @(negedge clk);
    @(posedge clk); #1;
    ch_valid = '0;
    chk("rr_grants", 32'(gq.size() >= 129), 32'd1);
    if (gq.size() >= 129) begin
      for (int i = 0; i < 9; i++) chk($sformatf("rr_ch_%0d", i), 32'(gq[i].ch), 32'(i % 8));
      bad = 0;
      for (int i = 1; i < 129; i++)
        if (gq[i].cyc - gq[i-1].cyc != 22 || gq[i].ch != i % 8) bad++;
      chk("rr_spacing_order", 32'(bad), 32'd0);
      early = 0;
      foreach (oq[i]) if (oq[i].cyc < gq[120].cyc) early++;
      chk("rr_no_early_out", 32'(early), 32'd0);
      chk("rr_first_out_cyc", (oq.size() > 0) ? 32'(oq[0].cyc - gq[120].cyc) : 32'hFFFF_FFFF, 32'd21);
      chk("rr_first_out_ch",  (oq.size() > 0) ? 32'(oq[0].ch) : 32'hFFFF_FFFF, 32'd0);
    end

    // DC gain on ch3: 0x0400_0000 * 32766 >> 14
    do_reset();
    oq.delete();
    for (int i = 0; i < 18; i++) send(3, 32'h0400_0000, g);
    tick(30);
    chk("dc_count", 32'(oq.size()), 32'd3);
    foreach (oq[i]) begin
      chk($sformatf("dc_data_%0d", i), oq[i].d, 32'h07FF_E000);
      chk($sformatf("dc_ch_%0d", i), 32'(oq[i].ch), 32'd3);
    end

    // Backpressure: hold out_ready low with ch5 requesting
    out_ready = 1'b0;
    oq.delete();
    send(3, 32'h0400_0000, g);
    ch_data[5] = 32'h0; ch_valid[5] = 1'b1;
    wait_ov("bp_valid");
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("bp_valid_%0d", t), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data_%0d", t),  out_data, 32'h07FF_E000);
      chk($sformatf("bp_ch_%0d", t),    32'(out_ch), 32'd3);
      chk($sformatf("bp_ready_%0d", t), 32'(ch_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_after_grant", 32'(ch_ready), 32'h20);
    chk("bp_one_xfer", 32'(oq.size()), 32'd1);
    @(posedge clk); #1;
    ch_valid[5] = 1'b0;
    tick(30);

    // Flush mid-MAC on a primed channel
    oq.delete();
    send(3, 32'h0400_0000, g);
    tick(5);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(40);
    chk("flush_no_out", 32'(oq.size()), 32'd0);
    for (int i = 0; i < 15; i++) send(3, 32'h0400_0000, g);
    tick(30);
    chk("flush_refill_quiet", 32'(oq.size()), 32'd0);
    send(3, 32'h0400_0000, g);
    tick(30);
    chk("flush_resume", 32'(oq.size()), 32'd1);
    if (oq.size() == 1) chk("flush_resume_data", oq[0].d, 32'h07FF_E000);

    // Reset while holding an output
    out_ready = 1'b0;
    send(3, 32'h0400_0000, g);
    wait_ov("r6_valid");
    ch_valid = '1;
    @(negedge clk);
    chk("r6_no_grant_in_out", 32'(ch_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("r6_out_valid", 32'(out_valid), 32'd0);
    chk("r6_ch_ready",  32'(ch_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("r6_first_grant", 32'(ch_ready), 32'h01);
    @(posedge clk); #1;
    ch_valid = '0; out_ready = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
